// File: rtl/dcache_core_responder_if.sv
// ============================================================================
// Module      : dcache_core_responder_if
// Description : Core <-> D-cache request/response bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_core_responder_if #(
    parameter int TAG_W = 13
);
    logic             reqcyc;
    logic [63:0]      req;
    logic [TAG_W-1:0] reqtag;
    logic             reqack;
    logic             respcyc;
    logic [63:0]      resp;
    logic [TAG_W-1:0] resptag;
    logic             respack;

    modport master (
        output reqcyc, req, reqtag, respack,
        input  reqack, respcyc, resp, resptag
    );

    modport slave (
        input  reqcyc, req, reqtag, respack,
        output reqack, respcyc, resp, resptag
    );
endinterface

`default_nettype wire

// File: rtl/dcache_core_responder.sv
// ============================================================================
// Module      : dcache_core_responder
// Description : Direct-mapped read-only D-cache responder with burst line fill.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_core_responder #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 8,
    parameter int TAG_W      = 13
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    dcache_core_responder_if.slave    core,
    input  wire logic                 flush,
    output logic                      mem_reqcyc,
    output logic [63:0]               mem_req,
    input  wire logic                 mem_reqack,
    input  wire logic                 mem_respcyc,
    input  wire logic [63:0]          mem_resp,
    output logic                      mem_respack,
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
    output logic                      err
);
    localparam int c_OFF_W  = $clog2(LINE_WORDS * 8);
    localparam int c_IDX_W  = $clog2(NUM_LINES);
    localparam int c_WRD_W  = $clog2(LINE_WORDS);
    localparam int c_ATAG_W = 64 - c_OFF_W - c_IDX_W;
    localparam logic [c_WRD_W-1:0] c_LAST_BEAT = c_WRD_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOOKUP   = 3'd1,
        S_MISS_REQ = 3'd2,
        S_FILL     = 3'd3,
        S_RESPOND  = 3'd4
    } state_t;

    state_t r_state, w_next;

    logic [63:3]          r_addr;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_reqack;
    logic                 r_respcyc;
    logic [63:0]          r_resp;
    logic                 r_mem_reqcyc;
    logic [63:0]          r_mem_req;
    logic [31:0]          r_hits;
    logic [31:0]          r_misses;
    logic                 r_err;
    logic                 r_flush_pend;
    logic [c_WRD_W-1:0]   r_beat;
    logic [NUM_LINES-1:0] r_valid;

    logic [c_ATAG_W-1:0]  r_tags [NUM_LINES];
    logic [63:0]          r_data [NUM_LINES*LINE_WORDS];

    logic [c_WRD_W-1:0]   w_word;
    logic [c_IDX_W-1:0]   w_index;
    logic [c_ATAG_W-1:0]  w_atag;
    logic                 w_is_read;
    logic                 w_hit;
    logic                 w_flush_now;
    logic                 w_last_beat;

    assign w_word      = r_addr[c_OFF_W-1:3];
    assign w_index     = r_addr[c_OFF_W+c_IDX_W-1:c_OFF_W];
    assign w_atag      = r_addr[63:c_OFF_W+c_IDX_W];
    assign w_is_read   = r_tag[0];
    assign w_hit       = r_valid[w_index] && (r_tags[w_index] == w_atag);
    // A flush pulse arriving while idle is honoured immediately, ahead of a request
    assign w_flush_now = r_flush_pend | flush;
    assign w_last_beat = mem_respcyc && (r_beat == c_LAST_BEAT);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (!w_flush_now && core.reqcyc) w_next = S_LOOKUP;
            S_LOOKUP:   w_next = (!w_is_read || w_hit) ? S_RESPOND : S_MISS_REQ;
            S_MISS_REQ: if (mem_reqack) w_next = S_FILL;
            S_FILL:     if (w_last_beat) w_next = S_RESPOND;
            S_RESPOND:  if (r_respcyc && core.respack) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_tag        <= '0;
            r_reqack     <= 1'b0;
            r_respcyc    <= 1'b0;
            r_resp       <= '0;
            r_mem_reqcyc <= 1'b0;
            r_mem_req    <= '0;
            r_hits       <= '0;
            r_misses     <= '0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_beat       <= '0;
            r_valid      <= '0;
        end else begin
            r_reqack     <= 1'b0;
            r_flush_pend <= (r_state == S_IDLE) ? 1'b0 : (r_flush_pend | flush);
            case (r_state)
                S_IDLE: begin
                    if (w_flush_now) begin
                        r_valid <= '0;
                    end else if (core.reqcyc) begin
                        r_addr   <= core.req[63:3];
                        r_tag    <= core.reqtag;
                        r_reqack <= 1'b1;
                    end
                end
                S_LOOKUP: begin
                    if (!w_is_read) begin
                        r_resp <= '0;
                        r_err  <= 1'b1;
                    end else if (w_hit) begin
                        r_resp <= r_data[{w_index, w_word}];
                        r_hits <= r_hits + 32'd1;
                    end else begin
                        r_mem_reqcyc <= 1'b1;
                        r_mem_req    <= {r_addr[63:c_OFF_W], {c_OFF_W{1'b0}}};
                        r_misses     <= r_misses + 32'd1;
                    end
                end
                S_MISS_REQ: begin
                    if (mem_reqack) begin
                        r_mem_reqcyc <= 1'b0;
                        r_beat       <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_respcyc) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_word) r_resp <= mem_resp;
                        if (w_last_beat) r_valid[w_index] <= 1'b1;
                    end
                end
                S_RESPOND: begin
                    // respcyc rises one cycle after entry so hits answer at E+2
                    if (!r_respcyc)           r_respcyc <= 1'b1;
                    else if (core.respack)    r_respcyc <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_FILL && mem_respcyc) begin
            r_data[{w_index, r_beat}] <= mem_resp;
            if (w_last_beat) r_tags[w_index] <= w_atag;
        end
    end

    assign core.reqack  = r_reqack;
    assign core.respcyc = r_respcyc;
    assign core.resp    = r_resp;
    assign core.resptag = r_tag;
    assign mem_reqcyc   = r_mem_reqcyc;
    assign mem_req      = r_mem_req;
    assign mem_respack  = (r_state == S_FILL);
    assign hit_count    = r_hits;
    assign miss_count   = r_misses;
    assign err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dcache_core_responder.sv
// ============================================================================
// Module      : tb_dcache_core_responder
// Description : Directed self-checking bench for dcache_core_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_core_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        mem_reqcyc;
    logic [63:0] mem_req;
    logic        mem_reqack;
    logic        mem_respcyc;
    logic [63:0] mem_resp;
    logic        mem_respack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    dcache_core_responder_if #(.TAG_W(13)) bus ();

    dcache_core_responder #(
        .NUM_LINES(64), .LINE_WORDS(8), .TAG_W(13)
    ) dut (
        .clk(clk), .reset(reset), .core(bus.slave), .flush(flush),
        .mem_reqcyc(mem_reqcyc), .mem_req(mem_req), .mem_reqack(mem_reqack),
        .mem_respcyc(mem_respcyc), .mem_resp(mem_resp), .mem_respack(mem_respack),
        .hit_count(hit_count), .miss_count(miss_count), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [63:0] addr, input logic [12:0] tag);
        bus.reqcyc = 1'b1;
        bus.req    = addr;
        bus.reqtag = tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.reqack) break;
        end
        check("reqack", bus.reqack, 1);
        bus.reqcyc = 1'b0;
    endtask

    task automatic fill(input logic [63:0] line_addr, input logic [63:0] base, input int nbeats);
        for (int i = 0; i < 10; i++) begin
            if (mem_reqcyc) break;
            @(negedge clk);
        end
        check("mem_reqcyc", mem_reqcyc, 1);
        check("mem_req", mem_req, line_addr);
        mem_reqack = 1'b1;
        @(negedge clk);
        mem_reqack = 1'b0;
        check("mem_reqcyc_drop", mem_reqcyc, 0);
        check("mem_respack", mem_respack, 1);
        for (int i = 0; i < nbeats; i++) begin
            mem_respcyc = 1'b1;
            mem_resp    = base + 64'(i);
            @(negedge clk);
        end
        mem_respcyc = 1'b0;
    endtask

    task automatic get_resp(input logic [63:0] exp_data, input logic [12:0] exp_tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.respcyc) break;
            @(negedge clk);
        end
        check("respcyc", bus.respcyc, 1);
        check("resp", bus.resp, exp_data);
        check("resptag", bus.resptag, 64'(exp_tag));
        bus.respack = 1'b1;
        @(negedge clk);
        bus.respack = 1'b0;
        check("respcyc_drop", bus.respcyc, 0);
    endtask

    task automatic check_zero_outputs();
        check("rst_reqack", bus.reqack, 0);
        check("rst_respcyc", bus.respcyc, 0);
        check("rst_resp", bus.resp, 0);
        check("rst_resptag", bus.resptag, 0);
        check("rst_mem_reqcyc", mem_reqcyc, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_respack", mem_respack, 0);
        check("rst_err", err, 0);
        check("rst_hits", hit_count, 0);
        check("rst_misses", miss_count, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        bus.reqcyc = 1'b0; bus.req = '0; bus.reqtag = '0; bus.respack = 1'b0;
        mem_reqack = 1'b0; mem_respcyc = 1'b0; mem_resp = '0;
        @(negedge clk); @(negedge clk);
        check_zero_outputs();
        reset = 1'b0;
        @(negedge clk);

        // Cold miss on 0x1000, word 0 of the refilled line
        issue(64'h1000, 13'h0A5);
        fill(64'h1000, 64'hA0, 8);
        get_resp(64'hA0, 13'h0A5);
        check("miss_count1", miss_count, 1);

        // Hit on 0x1008 with exact latency: reqack after E, respcyc only after E+2
        issue(64'h1008, 13'h123);
        check("lat_respcyc_E", bus.respcyc, 0);
        @(negedge clk);
        check("lat_reqack_E1", bus.reqack, 0);
        check("lat_respcyc_E1", bus.respcyc, 0);
        @(negedge clk);
        check("lat_respcyc_E2", bus.respcyc, 1);
        check("hit_no_memreq", mem_reqcyc, 0);
        get_resp(64'hA1, 13'h123);
        check("hit_count1", hit_count, 1);

        // Conflict miss on the same index evicts, then the original line misses again
        issue(64'h2000, 13'h0A5);
        fill(64'h2000, 64'hB0, 8);
        get_resp(64'hB0, 13'h0A5);
        issue(64'h1018, 13'h1FFF);
        fill(64'h1000, 64'hC0, 8);
        get_resp(64'hC3, 13'h1FFF);
        check("miss_count3", miss_count, 3);

        // Back-pressured response stays stable; new requests are ignored meanwhile
        issue(64'h1010, 13'h0A5);
        for (int i = 0; i < 10; i++) begin
            if (bus.respcyc) break;
            @(negedge clk);
        end
        bus.reqcyc = 1'b1; bus.req = 64'h5000; bus.reqtag = 13'h0777;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_respcyc", bus.respcyc, 1);
            check("hold_resp", bus.resp, 64'hC2);
            check("hold_resptag", bus.resptag, 64'h0A5);
            check("hold_no_reqack", bus.reqack, 0);
        end
        bus.reqcyc = 1'b0;
        bus.respack = 1'b1;
        @(negedge clk);
        bus.respack = 1'b0;
        check("hold_release", bus.respcyc, 0);
        check("hit_count2", hit_count, 2);

        // WRITE request is answered with zero data and latches err
        issue(64'h40, 13'h0B2);
        get_resp(64'h0, 13'h0B2);
        check("err_set", err, 1);
        @(negedge clk); @(negedge clk);
        check("err_sticky", err, 1);
        check("write_no_miss", miss_count, 3);

        // Reset during FILL abandons the line
        issue(64'h3000, 13'h0A5);
        fill(64'h3000, 64'hD0, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero_outputs();
        issue(64'h1000, 13'h0A5);
        fill(64'h1000, 64'hE0, 8);
        get_resp(64'hE0, 13'h0A5);
        check("post_rst_miss", miss_count, 1);

        // Flush while responding invalidates the store once back in IDLE
        issue(64'h1008, 13'h0A5);
        for (int i = 0; i < 10; i++) begin
            if (bus.respcyc) break;
            @(negedge clk);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        get_resp(64'hE1, 13'h0A5);
        check("pre_flush_hits", hit_count, 1);
        issue(64'h1008, 13'h0A5);
        fill(64'h1000, 64'hF0, 8);
        get_resp(64'hF1, 13'h0A5);
        check("flush_miss", miss_count, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
